dp_ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM (N=4, D=16, W=8 defaults) and drives its port pins. Port A is the write port; port B is the read port. The block turns a push/pop interface into RAM addresses, write enables and chip-select. It returns RAM port-B read data to the consumer with a registered valid strobe.

---
 rtl/dp_ram_fifo_ctrl_pkg.sv | 14 +
 rtl/dp_ram_fifo_ctrl_if.sv | 44 ++++
 rtl/dp_ram_fifo_ctrl.sv | 80 ++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// Shared defaults and elaboration helpers for the dual-port-RAM FIFO controller.
package dp_ram_fifo_ctrl_pkg;

    localparam int DEF_N = 4;   // address width of the attached RAM
    localparam int DEF_D = 16;  // FIFO depth, always 2**N
    localparam int DEF_W = 8;   // data width of the attached RAM

    // The pointer-based full/empty decode only works when the depth fills
    // the whole RAM address space.
    function automatic bit depth_matches(input int n, input int d);
        return d == (1 << n);
    endfunction

endpackage

// File: rtl/dp_ram_fifo_ctrl_if.sv
// Push/pop handshake plus RAM pin bundle for the FIFO controller.
// Handshake: a PUSH or POP is a single-cycle request sampled on CLK; it is
// accepted when FULL/EMPTY allow it (push while full needs an accepted pop in
// the same cycle). Popped data appears one cycle later on POP_DATA, qualified
// by POP_VALID; POP_DATA is meaningless while POP_VALID is low.
interface dp_ram_fifo_ctrl_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic         PUSH;
    logic [W-1:0] PUSH_DATA;
    logic         FULL;
    logic         POP;
    logic [W-1:0] POP_DATA;
    logic         POP_VALID;
    logic         EMPTY;
    logic [N:0]   COUNT;
    logic         OVF;
    logic         UDF;
    logic         RAM_CS;
    logic         RAM_WR_RD_A;
    logic         RAM_WR_RD_B;
    logic [N-1:0] RAM_ADDR_A;
    logic [N-1:0] RAM_ADDR_B;
    logic [W-1:0] RAM_WDATA_A;
    logic [W-1:0] RAM_WDATA_B;
    logic [W-1:0] RAM_RDATA_B;

    // Producer/consumer and RAM side of the controller.
    modport master (
        output PUSH, PUSH_DATA, POP, RAM_RDATA_B,
        input  FULL, POP_DATA, POP_VALID, EMPTY, COUNT, OVF, UDF,
        input  RAM_CS, RAM_WR_RD_A, RAM_WR_RD_B, RAM_ADDR_A, RAM_ADDR_B,
        input  RAM_WDATA_A, RAM_WDATA_B
    );

    // The controller itself.
    modport slave (
        input  PUSH, PUSH_DATA, POP, RAM_RDATA_B,
        output FULL, POP_DATA, POP_VALID, EMPTY, COUNT, OVF, UDF,
        output RAM_CS, RAM_WR_RD_A, RAM_WR_RD_B, RAM_ADDR_A, RAM_ADDR_B,
        output RAM_WDATA_A, RAM_WDATA_B
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port A writes, port B reads.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int D = DEF_D,
    parameter int W = DEF_W
) (
    input logic              CLK,
    input logic              RST,
    dp_ram_fifo_ctrl_if.slave bus
);

    generate
        if (!depth_matches(N, D)) begin : g_bad_depth
            $error("dp_ram_fifo_ctrl: D must equal 2**N");
        end
    endgenerate

    logic [N:0] wptr;
    logic [N:0] rptr;
    logic       pop_valid_q;
    logic       ovf_q;
    logic       udf_q;
    logic       empty;
    logic       full;
    logic       rd_en;
    logic       wr_en;

    // Status decodes straight from the pointers.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[N-1:0] == rptr[N-1:0]) && (wptr[N] != rptr[N]);
    end

    // Request acceptance; reset holds both off so the RAM stays deselected.
    // A push into a full FIFO is fine when a pop frees the slot on the same
    // edge: the RAM reads the old word before the write lands.
    always_comb begin
        rd_en = !RST && bus.POP && !empty;
        wr_en = !RST && bus.PUSH && (!full || rd_en);
    end

    // Pointer, read-valid and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr        <= '0;
            rptr        <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wptr        <= wptr + (N+1)'(wr_en);
            rptr        <= rptr + (N+1)'(rd_en);
            pop_valid_q <= rd_en;
            ovf_q       <= ovf_q | (bus.PUSH && full && !rd_en);
            udf_q       <= udf_q | (bus.POP && empty);
        end
    end

    // Consumer-facing outputs and RAM pin drive.
    always_comb begin
        bus.FULL        = full;
        bus.EMPTY       = empty;
        bus.COUNT       = wptr - rptr;
        bus.OVF         = ovf_q;
        bus.UDF         = udf_q;
        bus.POP_VALID   = pop_valid_q;
        bus.POP_DATA    = bus.RAM_RDATA_B;
        bus.RAM_CS      = !(wr_en || rd_en);
        bus.RAM_WR_RD_A = wr_en;
        bus.RAM_WR_RD_B = 1'b0;
        bus.RAM_ADDR_A  = wptr[N-1:0];
        bus.RAM_ADDR_B  = rptr[N-1:0];
        bus.RAM_WDATA_A = bus.PUSH_DATA;
        bus.RAM_WDATA_B = '0;
    end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// a directed vector table, directed corner sequences and random traffic.
module tb_dp_ram_fifo_ctrl;

    localparam int N = 4;
    localparam int D = 16;
    localparam int W = 8;

    logic clk;
    logic rst;

    dp_ram_fifo_ctrl_if #(.N(N), .W(W)) bus ();

    dp_ram_fifo_ctrl #(.N(N), .D(D), .W(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural dual-port RAM ----------------
    logic [W-1:0] mem [D];
    initial bus.RAM_RDATA_B = '0;
    always @(posedge clk) begin
        if (!bus.RAM_CS) begin
            if (bus.RAM_WR_RD_A) mem[bus.RAM_ADDR_A] <= bus.RAM_WDATA_A;
            bus.RAM_RDATA_B <= mem[bus.RAM_ADDR_B];
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic         m_ovf, m_udf, m_pv;
    logic [W-1:0] m_pd;
    int           wr_total, rd_total;
    int           n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(bus.COUNT), 32'(exp_q.size()));
        chk("empty", 32'(bus.EMPTY), 32'(exp_q.size() == 0));
        chk("full", 32'(bus.FULL), 32'(exp_q.size() == D));
        chk("pop_valid", 32'(bus.POP_VALID), 32'(m_pv));
        chk("ovf", 32'(bus.OVF), 32'(m_ovf));
        chk("udf", 32'(bus.UDF), 32'(m_udf));
        if (m_pv) chk("pop_data", 32'(bus.POP_DATA), 32'(m_pd));
    endtask

    // One clock of traffic: check RAM drive before the edge, outputs after.
    task automatic step(input logic push, input logic [W-1:0] d, input logic pop);
        logic m_empty, m_full, m_rd, m_wr;
        bus.PUSH      = push;
        bus.PUSH_DATA = d;
        bus.POP       = pop;
        m_empty = (exp_q.size() == 0);
        m_full  = (exp_q.size() == D);
        m_rd    = pop && !m_empty;
        m_wr    = push && (!m_full || m_rd);
        #1;
        chk("ram_cs", 32'(bus.RAM_CS), 32'(!(m_rd || m_wr)));
        chk("ram_wr_a", 32'(bus.RAM_WR_RD_A), 32'(m_wr));
        chk("ram_wr_b", 32'(bus.RAM_WR_RD_B), 32'd0);
        chk("ram_wdata_b", 32'(bus.RAM_WDATA_B), 32'd0);
        if (m_wr) begin
            chk("ram_addr_a", 32'(bus.RAM_ADDR_A), 32'(wr_total % D));
            chk("ram_wdata_a", 32'(bus.RAM_WDATA_A), 32'(d));
        end
        if (m_rd) chk("ram_addr_b", 32'(bus.RAM_ADDR_B), 32'(rd_total % D));
        @(posedge clk);
        #1;
        if (push && m_full && !m_rd) m_ovf = 1'b1;
        if (pop && m_empty) m_udf = 1'b1;
        m_pv = m_rd;
        if (m_rd) begin
            m_pd = exp_q.pop_front();
            rd_total++;
        end
        if (m_wr) begin
            exp_q.push_back(d);
            wr_total++;
        end
        check_outputs();
    endtask

    // Reset with requests held high: the RAM must stay deselected.
    task automatic do_reset();
        rst           = 1'b1;
        bus.PUSH      = 1'b1;
        bus.POP       = 1'b1;
        bus.PUSH_DATA = 8'hEE;
        #1;
        chk("rst_ram_cs", 32'(bus.RAM_CS), 32'd1);
        chk("rst_ram_wr_a", 32'(bus.RAM_WR_RD_A), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_pv = 1'b0; m_pd = '0;
        wr_total = 0; rd_total = 0;
        check_outputs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         push;
        logic [W-1:0] d;
        logic         pop;
        int           cnt;
        logic         pv;
        logic [W-1:0] pd;
        logic         udf;
        logic         ovf;
    } vec_t;

    vec_t vt [7];

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0;
        bus.PUSH = 1'b0; bus.POP = 1'b0; bus.PUSH_DATA = '0;

        //           push  data   pop  cnt pv  pd     udf ovf
        vt[0] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0}; // pop on empty
        vt[1] = '{1'b1, 8'h21, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{1'b1, 8'h22, 1'b1, 1, 1'b1, 8'h21, 1'b1, 1'b0};
        vt[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h22, 1'b1, 1'b0};
        vt[4] = '{1'b1, 8'h23, 1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0}; // push+pop on empty
        vt[5] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h23, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(vt[i].push, vt[i].d, vt[i].pop);
            chk("tbl_count", 32'(bus.COUNT), 32'(vt[i].cnt));
            chk("tbl_pop_valid", 32'(bus.POP_VALID), 32'(vt[i].pv));
            if (vt[i].pv) chk("tbl_pop_data", 32'(bus.POP_DATA), 32'(vt[i].pd));
            chk("tbl_udf", 32'(bus.UDF), 32'(vt[i].udf));
            chk("tbl_ovf", 32'(bus.OVF), 32'(vt[i].ovf));
        end

        // Fill to full, extra push rejected, drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_count", 32'(bus.COUNT), 32'd16);
        chk("fill_ovf", 32'(bus.OVF), 32'd0);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_set", 32'(bus.OVF), 32'd1);
        chk("ovf_count", 32'(bus.COUNT), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(bus.POP_DATA), 32'(8'h10 + i));
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_empty", 32'(bus.EMPTY), 32'd1);
        chk("drain_pv_low", 32'(bus.POP_VALID), 32'd0);

        // Full, then push+pop together: old head comes out, new word at tail.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        chk("fullpp_data", 32'(bus.POP_DATA), 32'h10);
        chk("fullpp_count", 32'(bus.COUNT), 32'd16);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("fullpp_last", 32'(bus.POP_DATA), 32'h55);

        // Address wrap with interleaved push/pop.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0);
            chk("wrap_cnt_le1", 32'(bus.COUNT <= 1), 32'd1);
            step(1'b0, 8'h00, 1'b1);
            chk("wrap_data", 32'(bus.POP_DATA), 32'(8'h80 + i));
        end

        // Underflow then reset mid-stream at COUNT=5.
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        chk("udf_set", 32'(bus.UDF), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.COUNT), 32'd5);
        do_reset();
        chk("post_rst_count", 32'(bus.COUNT), 32'd0);
        chk("post_rst_udf", 32'(bus.UDF), 32'd0);

        // Random traffic with phases biased toward filling and draining.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 60) % 2 == 0) ? 80 : 25;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < bias, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) >= bias - 10);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
